max7219_word_tx: RTL and testbench
==================================

MAX7219_WORD_TX -- requirements
Module: max7219_word_tx

Interface
REQ-001 Parameter CLK_DIV, default 4: number of clk cycles in each sclk half-period; legal range 1..255.
REQ-002 Parameter CS_GAP, default 2: minimum number of clk cycles cs stays high after a word, before the next word can be accepted; legal range 1..255.
REQ-003 clk  input  1  system clock; all logic is on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 word_in  input  16  {register address[15:8], data[7:0]} for one MAX7219 write.
REQ-006 word_valid  input  1  upstream command sequencer offers word_in.
REQ-007 word_ready  output  1  block can accept a word; registered.
REQ-008 busy  output  1  a word is in flight, from acceptance until the gap ends.
REQ-009 done  output  1  one-cycle pulse when cs rises at the end of a word.
REQ-010 mosi  output  1  serial data, MSB first.
REQ-011 sclk  output  1  SPI clock, idle low; the device samples on the rising edge.
REQ-012 cs  output  1  chip select/LOAD, active-low; held low for all 16 bits of one word.

Function
REQ-013 States are IDLE, SETUP, HIGH, LOW, GAP.
- One divider counter (0..CLK_DIV-1).
- One bit counter (0..15).
- One 16-bit shift register.
REQ-014 Accept occurs on the clk edge where word_valid=1 and word_ready=1. On that edge:
- shift register loads word_in;
- mosi loads word_in[15];
- cs goes 0;
- word_ready goes 0 and busy goes 1;
- state goes to SETUP.
REQ-015 SETUP: sclk=0 for CLK_DIV cycles (mosi setup time), then go to HIGH.
REQ-016 HIGH: sclk=1 for CLK_DIV cycles; mosi stays stable; then go to LOW.
REQ-017 LOW: sclk=0 for CLK_DIV cycles.
- On entry to LOW, mosi takes the next bit.
- After the 16th HIGH, mosi holds its last value.
- At the end of LOW: if the bit counter is below 15, increment it and go to HIGH; otherwise go to GAP.
REQ-018 Going from the 16th LOW to GAP:
- cs goes 1 and done pulses for exactly 1 cycle;
- cs low lasts exactly 33*CLK_DIV cycles;
- exactly 16 sclk rising edges occur while cs=0.
REQ-019 GAP: cs=1, sclk=0 for CS_GAP cycles. Then word_ready goes 1, busy goes 0, state goes to IDLE.
REQ-020 While word_ready=0, word_valid and word_in are ignored; the in-flight word is never modified.
REQ-021 Back-to-back words (word_valid held): cs stays high for exactly CS_GAP+1 cycles between consecutive words.
REQ-022 sclk never toggles and mosi never changes while cs=1.

Reset
REQ-023 While reset=0 (checked synchronously, overriding all else, including mid-word):
- cs=1, sclk=0, mosi=0, done=0, busy=0, word_ready=0;
- state=IDLE and all counters cleared;
- the partial word is discarded with no done pulse.
REQ-024 word_ready goes 1 on the first clk edge with reset=1.

Verification
REQ-025 CLK_DIV=4, word_in=16'h0C01 accepted once -> cs low exactly 132 cycles; 16 rising edges sample 0000_1100_0000_0001; one done pulse coincides with cs rising.
REQ-026 CLK_DIV=4, CS_GAP=2, word_valid held with 16'h0900 then 16'h0A0A -> two complete frames, cs high exactly 3 cycles between them, two done pulses.
REQ-027 Toggle word_valid and change word_in during a transfer of 16'h0B07 -> serial bits remain 16'h0B07; no second accept until word_ready=1.
REQ-028 Assert reset=0 after the 7th rising edge of sclk -> next cycle cs=1, sclk=0, mosi=0, busy=0, no done; after release word_ready=1 and a new word transfers intact.
REQ-029 CLK_DIV=1, word_in=16'hFFFF -> cs low 33 cycles, sclk alternates every cycle, mosi=1 at all 16 rising edges.
REQ-030 Idle for 1000 cycles with word_valid=0 -> cs=1, sclk=0, done=0 throughout.

Source files
------------

// File: rtl/max7219_word_tx.sv
// Serialises one 16-bit {address, data} word to a MAX7219 over SPI (mode 0),
// framing it with an active-low LOAD/cs and enforcing a minimum cs-high gap.
module max7219_word_tx #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        busy,
  output logic        done,
  output logic        mosi,
  output logic        sclk,
  output logic        cs
);

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned BIT_W    = 4;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(15);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [15:0]      shift_q, shift_d;
  logic             mosi_q, mosi_d;
  logic             sclk_q, sclk_d;
  logic             cs_q, cs_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             div_end_c;

  assign div_end_c = (div_q == DIV_LAST);

  // State and output registers; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      mosi_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      mosi_q  <= mosi_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic; shift_q holds the bits still to be presented on mosi.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    mosi_d  = mosi_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    ready_d = ready_q;

    case (state_q)
      S_IDLE: begin
        if (ready_q && word_valid) begin
          shift_d = {word_in[14:0], 1'b0};
          mosi_d  = word_in[15];
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          state_d = S_SETUP;
        end else begin
          ready_d = 1'b1;
        end
      end

      S_SETUP: begin
        if (div_end_c) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end

      S_HIGH: begin
        if (div_end_c) begin
          div_d   = '0;
          sclk_d  = 1'b0;
          state_d = S_LOW;
          // The last bit stays on mosi once the 16th edge has sampled it.
          if (bit_q != BIT_LAST) begin
            mosi_d  = shift_q[15];
            shift_d = {shift_q[14:0], 1'b0};
          end
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end

      S_LOW: begin
        if (div_end_c) begin
          div_d = '0;
          if (bit_q != BIT_LAST) begin
            bit_d   = bit_q + BIT_W'(1);
            sclk_d  = 1'b1;
            state_d = S_HIGH;
          end else begin
            bit_d   = '0;
            cs_d    = 1'b1;
            done_d  = 1'b1;
            state_d = S_GAP;
          end
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end

      S_GAP: begin
        if (div_q == GAP_LAST) begin
          div_d   = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign word_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign mosi       = mosi_q;
  assign sclk       = sclk_q;
  assign cs         = cs_q;

endmodule

// File: tb/tb_max7219_word_tx.sv
// Bench for max7219_word_tx: a frame monitor reconstructs each word from the
// pins and compares it with a queue of words the bench itself handed over.
module tb_max7219_word_tx;

  localparam int unsigned DIV0 = 4;
  localparam int unsigned GAP0 = 2;
  localparam int unsigned DIV1 = 1;
  localparam int unsigned GAP1 = 1;
  localparam int BOUND = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] w0, w1;
  logic        v0, v1;
  logic        r0, b0, d0, m0, s0, c0;
  logic        r1, b1, d1, m1, s1, c1;

  max7219_word_tx #(.CLK_DIV(DIV0), .CS_GAP(GAP0)) u_dut (
    .clk(clk), .reset(rst_n), .word_in(w0), .word_valid(v0),
    .word_ready(r0), .busy(b0), .done(d0), .mosi(m0), .sclk(s0), .cs(c0)
  );

  max7219_word_tx #(.CLK_DIV(DIV1), .CS_GAP(GAP1)) u_dut1 (
    .clk(clk), .reset(rst_n), .word_in(w1), .word_valid(v1),
    .word_ready(r1), .busy(b1), .done(d1), .mosi(m1), .sclk(s1), .cs(c1)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: words accepted, in order; each must reappear as one frame.
  logic [15:0] exp_q[$];

  int          m_low, m_edges, m_hi, m_last_hi, m_err, m_idle_err, m_done_cnt;
  logic [15:0] m_bits, m_exp;
  logic        m_cs_prev = 1'b1, m_sclk_prev = 1'b0, m_mosi_prev = 1'b0;

  initial begin
    m_low = 0; m_edges = 0; m_hi = 0; m_last_hi = 0; m_err = 0;
    m_idle_err = 0; m_done_cnt = 0; m_bits = '0;
  end

  // Frame monitor for the CLK_DIV=4 instance, sampling 1 time unit after each edge.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      m_cs_prev   = 1'b1;
      m_sclk_prev = 1'b0;
      m_mosi_prev = 1'b0;
      m_err       = 0;
    end else begin
      if (c0 === 1'b0) begin
        if (m_cs_prev) begin
          m_low = 0; m_bits = '0; m_edges = 0; m_last_hi = m_hi;
        end
        m_low++;
        if (s0 && !m_sclk_prev) begin
          m_bits = {m_bits[14:0], m0};
          m_edges++;
        end
        if (d0 !== 1'b0 || b0 !== 1'b1 || r0 !== 1'b0) m_err++;
      end else begin
        if (!m_cs_prev) begin
          if (d0 === 1'b1) m_done_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
          end else begin
            m_exp = exp_q.pop_front();
            check("frame_bits", 32'(m_bits), 32'(m_exp));
            check("cs_low_len", 32'(m_low), 32'(33 * DIV0));
            check("sclk_edges", 32'(m_edges), 32'd16);
            check("done_at_cs_rise", 32'(d0), 32'd1);
            check("frame_glitches", 32'(m_err), 32'd0);
          end
          m_hi  = 1;
          m_err = 0;
        end else begin
          m_hi++;
          if (s0 !== 1'b0 || m0 !== m_mosi_prev || d0 !== 1'b0) m_idle_err++;
        end
      end
      m_cs_prev   = c0;
      m_sclk_prev = s0;
      m_mosi_prev = m0;
    end
  end

  // Offer a word, wait for the handshake, and record it in the model.
  task automatic send(input logic [15:0] w, input bit hold);
    int n;
    n  = 0;
    w0 = w;
    v0 = 1'b1;
    while (r0 !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) check("accept_timeout", 32'(n), 32'd0);
    exp_q.push_back(w);
    @(negedge clk);
    if (!hold) v0 = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || r0 !== 1'b1) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < BOUND), 32'd1);
  endtask

  typedef struct {
    logic [15:0] word;
    bit          hold;
    int          exp_gap;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int dc, err, cnt, n, low, edges, ones, alt_err, dones;
    logic prev;

    vecs[0] = '{16'h0C01, 1'b0, 0};
    vecs[1] = '{16'h0900, 1'b1, 0};
    vecs[2] = '{16'h0A0A, 1'b0, int'(GAP0 + 1)};
    vecs[3] = '{16'hFFFF, 1'b0, 0};
    vecs[4] = '{16'h0000, 1'b1, 0};
    vecs[5] = '{16'h8001, 1'b0, int'(GAP0 + 1)};
    vecs[6] = '{16'hA55A, 1'b0, 0};

    rst_n = 1'b0; v0 = 1'b0; w0 = '0; v1 = 1'b0; w1 = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({c0, s0, m0, b0, d0, r0}), 32'(6'b100000));
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'({r0, r1}), 32'(2'b11));

    // Table-driven words, including back-to-back pairs.
    dc = m_done_cnt;
    foreach (vecs[i]) begin
      send(vecs[i].word, vecs[i].hold);
      if (vecs[i].exp_gap != 0) check("cs_gap_b2b", 32'(m_last_hi), 32'(vecs[i].exp_gap));
    end
    v0 = 1'b0;
    wait_idle();
    check("table_done_pulses", 32'(m_done_cnt - dc), 32'd7);

    // Inputs churn during a transfer; the word in flight must stay intact.
    send(16'h0B07, 1'b0);
    err = 0;
    repeat (100) begin
      @(negedge clk);
      if (r0 !== 1'b0) err++;
      v0 = 1'($urandom);
      w0 = 16'($urandom);
    end
    v0 = 1'b0;
    check("ready_low_in_flight", 32'(err), 32'd0);
    wait_idle();

    // Randomised words and spacing.
    for (int i = 0; i < 20; i++) begin
      bit hold;
      hold = 1'($urandom_range(0, 1));
      send(16'($urandom), hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    v0 = 1'b0;
    wait_idle();

    // Reset after the 7th sclk rising edge.
    dc = m_done_cnt;
    send(16'h1234, 1'b0);
    cnt = 0; n = 0; prev = s0;
    while (cnt < 7 && n < BOUND) begin
      @(negedge clk);
      if (s0 && !prev) cnt++;
      prev = s0;
      n++;
    end
    check("seventh_edge_seen", 32'(cnt), 32'd7);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midword_reset_outputs", 32'({c0, s0, m0, b0, d0, r0}), 32'(6'b100000));
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midword_reset", 32'(r0), 32'd1);
    check("no_done_on_abort", 32'(m_done_cnt - dc), 32'd0);
    send(16'h0B07, 1'b0);
    wait_idle();

    // Long idle stretch.
    err = 0;
    repeat (1000) begin
      @(negedge clk);
      if (c0 !== 1'b1 || s0 !== 1'b0 || d0 !== 1'b0) err++;
    end
    check("idle_quiet", 32'(err), 32'd0);

    // CLK_DIV=1 instance with an all-ones word.
    w1 = 16'hFFFF; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    low = 0; edges = 0; ones = 0; alt_err = 0; dones = 0; prev = 1'b0;
    for (int k = 0; k < 45; k++) begin
      if (c1 === 1'b0) begin
        if (k != 0 && s1 == prev) alt_err++;
        if (s1 && !prev) begin
          edges++;
          if (m1 === 1'b1) ones++;
        end
        low++;
      end
      if (d1 === 1'b1) dones++;
      prev = s1;
      @(negedge clk);
    end
    check("div1_cs_low_len", 32'(low), 32'd33);
    check("div1_sclk_edges", 32'(edges), 32'd16);
    check("div1_mosi_ones", 32'(ones), 32'd16);
    check("div1_sclk_alternates", 32'(alt_err), 32'd0);
    check("div1_done_pulses", 32'(dones), 32'd1);
    check("div1_back_to_idle", 32'({c1, s1, r1, b1}), 32'(4'b1010));

    check("idle_glitches", 32'(m_idle_err), 32'd0);
    check("model_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
